// File: rtl/dct_pkg.sv
// Shared constants for the 8-point sequential DCT: coefficient values,
// per-(k,n) magnitude and sign tables, and the controller state encoding.
package dct_pkg;

  localparam logic [7:0] COEF_A = 8'd64;
  localparam logic [7:0] COEF_B = 8'd60;
  localparam logic [7:0] COEF_C = 8'd56;
  localparam logic [7:0] COEF_D = 8'd45;
  localparam logic [7:0] COEF_E = 8'd36;
  localparam logic [7:0] COEF_F = 8'd24;
  localparam logic [7:0] COEF_G = 8'd12;

  // MAG_TBL[k][n] = |M[k][n]|
  localparam logic [7:0] MAG_TBL [0:7][0:7] = '{
    '{COEF_A, COEF_A, COEF_A, COEF_A, COEF_A, COEF_A, COEF_A, COEF_A},
    '{COEF_B, COEF_D, COEF_E, COEF_G, COEF_G, COEF_E, COEF_D, COEF_B},
    '{COEF_C, COEF_F, COEF_F, COEF_C, COEF_C, COEF_F, COEF_F, COEF_C},
    '{COEF_D, COEF_G, COEF_B, COEF_E, COEF_E, COEF_B, COEF_G, COEF_D},
    '{COEF_A, COEF_A, COEF_A, COEF_A, COEF_A, COEF_A, COEF_A, COEF_A},
    '{COEF_E, COEF_B, COEF_G, COEF_D, COEF_D, COEF_G, COEF_B, COEF_E},
    '{COEF_F, COEF_C, COEF_C, COEF_F, COEF_F, COEF_C, COEF_C, COEF_F},
    '{COEF_G, COEF_E, COEF_D, COEF_B, COEF_B, COEF_D, COEF_E, COEF_G}
  };

  // NEG_TBL[k][n] is set where M[k][n] is negative
  localparam logic [7:0] NEG_TBL [0:7] = '{
    8'b0000_0000,
    8'b1111_0000,
    8'b0011_1100,
    8'b1000_1110,
    8'b0110_0110,
    8'b1011_0010,
    8'b0101_1010,
    8'b1010_1010
  };

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MAC  = 2'd1,
    ST_OUT  = 2'd2
  } dct_state_e;

endpackage

// File: rtl/dct_coeff_rom.sv
// Combinational coefficient lookup: (k,n) -> {sign, magnitude} of M[k][n].
module dct_coeff_rom
  import dct_pkg::*;
(
  input  logic [2:0] k,
  input  logic [2:0] n,
  output logic       neg,
  output logic [7:0] mag
);

  // Table read for the current row/column
  always_comb begin
    neg = NEG_TBL[k][n];
    mag = MAG_TBL[k][n];
  end

endmodule

// File: rtl/dct_1d_seq.sv
// Sequential 8-point 1-D DCT: one external multiply per cycle, 8 cycles per coefficient.
// Optional macro DCT_ROUND_SHIFT_EN scales each output by (sum+32)>>>6.
module dct_1d_seq
  import dct_pkg::*;
#(
  parameter int SIZE  = 8,
  parameter int ACC_W = SIZE + 9
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [8*SIZE-1:0]       in_data,
  input  logic                    approx_en_in,
  output logic [7:0]              mult_coeff,
  output logic [SIZE-1:0]         mult_mcand,
  output logic                    mult_approx_en,
  input  logic signed [SIZE+5:0]  mult_result,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [ACC_W-1:0] out_data,
  output logic [2:0]              out_idx,
  output logic                    out_last
);

  localparam int PROD_W = SIZE + 6;
`ifdef DCT_ROUND_SHIFT_EN
  localparam logic signed [ACC_W-1:0] ROUND_BIAS = ACC_W'(32);
  localparam int                      ROUND_SHIFT = 6;
`endif

  dct_state_e              state_r;
  dct_state_e              state_nx_s;
  logic [8*SIZE-1:0]       x_r;
  logic [2:0]              k_r;
  logic [2:0]              n_r;
  logic signed [ACC_W-1:0] acc_r;
  logic signed [ACC_W-1:0] out_data_r;
  logic                    approx_r;

  logic                    coef_neg_s;
  logic [7:0]              coef_mag_s;
  logic [SIZE-1:0]         sample_s;
  logic signed [ACC_W-1:0] prod_ext_s;
  logic signed [ACC_W-1:0] sum_s;
  logic signed [ACC_W-1:0] result_s;
`ifdef DCT_ROUND_SHIFT_EN
  logic signed [ACC_W-1:0] round_s;
`endif

  dct_coeff_rom u_coeff_rom (
    .k   (k_r),
    .n   (n_r),
    .neg (coef_neg_s),
    .mag (coef_mag_s)
  );

  // Current sample selection and signed accumulate of the returned product
  always_comb begin
    sample_s   = x_r[n_r*SIZE +: SIZE];
    prod_ext_s = {{(ACC_W-PROD_W){mult_result[PROD_W-1]}}, mult_result};
    if (coef_neg_s) begin
      sum_s = acc_r - prod_ext_s;
    end else begin
      sum_s = acc_r + prod_ext_s;
    end
  end

  // Final value written to out_data at the last tap of a row
`ifdef DCT_ROUND_SHIFT_EN
  always_comb begin
    round_s  = sum_s + ROUND_BIAS;
    result_s = round_s >>> ROUND_SHIFT;
  end
`else
  always_comb begin
    result_s = sum_s;
  end
`endif

  // Controller state register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Next-state logic
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (in_valid) begin
          state_nx_s = ST_MAC;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_MAC: begin
        if (n_r == 3'd7) begin
          state_nx_s = ST_OUT;
        end else begin
          state_nx_s = ST_MAC;
        end
      end
      ST_OUT: begin
        if (!out_ready) begin
          state_nx_s = ST_OUT;
        end else if (k_r == 3'd7) begin
          state_nx_s = ST_IDLE;
        end else begin
          state_nx_s = ST_MAC;
        end
      end
      default: state_nx_s = ST_IDLE;
    endcase
  end

  // Datapath: sample/approx capture, tap counters, accumulator, result register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      x_r        <= {(8*SIZE){1'b0}};
      approx_r   <= 1'b0;
      k_r        <= 3'd0;
      n_r        <= 3'd0;
      acc_r      <= {ACC_W{1'b0}};
      out_data_r <= {ACC_W{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (in_valid) begin
            x_r      <= in_data;
            approx_r <= approx_en_in;
            k_r      <= 3'd0;
            n_r      <= 3'd0;
            acc_r    <= {ACC_W{1'b0}};
          end
        end
        ST_MAC: begin
          n_r <= n_r + 3'd1;
          if (n_r == 3'd7) begin
            out_data_r <= result_s;
            acc_r      <= {ACC_W{1'b0}};
          end else begin
            acc_r <= sum_s;
          end
        end
        ST_OUT: begin
          // k wraps to 0 after the last row so idx/last read clean in IDLE
          if (out_ready) begin
            k_r <= k_r + 3'd1;
            n_r <= 3'd0;
          end
        end
        default: begin
          k_r <= 3'd0;
          n_r <= 3'd0;
        end
      endcase
    end
  end

  // Output decode; multiplier operands are forced to zero outside MAC
  always_comb begin
    in_ready       = rst_n && (state_r == ST_IDLE);
    out_valid      = (state_r == ST_OUT);
    out_data       = out_data_r;
    out_idx        = k_r;
    out_last       = (k_r == 3'd7);
    mult_approx_en = approx_r;
    if (state_r == ST_MAC) begin
      mult_coeff = coef_mag_s;
      mult_mcand = sample_s;
    end else begin
      mult_coeff = 8'd0;
      mult_mcand = {SIZE{1'b0}};
    end
  end

endmodule

// File: tb/tb_dct_1d_seq.sv
// Self-checking bench for dct_1d_seq: exact external multiplier model plus matrix reference.
module tb_dct_1d_seq;

  localparam int SIZE  = 8;
  localparam int ACC_W = SIZE + 9;

  localparam int MAT [0:7][0:7] = '{
    '{ 64,  64,  64,  64,  64,  64,  64,  64},
    '{ 60,  45,  36,  12, -12, -36, -45, -60},
    '{ 56,  24, -24, -56, -56, -24,  24,  56},
    '{ 45, -12, -60, -36,  36,  60,  12, -45},
    '{ 64, -64, -64,  64,  64, -64, -64,  64},
    '{ 36, -60,  12,  45, -45, -12,  60, -36},
    '{ 24, -56,  56, -24, -24,  56, -56,  24},
    '{ 12, -36,  45, -60,  60, -45,  36, -12}
  };

  logic                    clk;
  logic                    rst_n;
  logic                    in_valid;
  logic                    in_ready;
  logic [8*SIZE-1:0]       in_data;
  logic                    approx_en_in;
  logic [7:0]              mult_coeff;
  logic signed [SIZE-1:0]  mult_mcand;
  logic                    mult_approx_en;
  logic signed [SIZE+5:0]  mult_result;
  logic                    out_valid;
  logic                    out_ready;
  logic signed [ACC_W-1:0] out_data;
  logic [2:0]              out_idx;
  logic                    out_last;

  int checks   = 0;
  int failures = 0;
  logic signed [7:0] xv [8];
  bit toggle_g = 1'b0;

  dct_1d_seq #(.SIZE(SIZE), .ACC_W(ACC_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .approx_en_in(approx_en_in), .mult_coeff(mult_coeff),
    .mult_mcand(mult_mcand), .mult_approx_en(mult_approx_en),
    .mult_result(mult_result), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_idx(out_idx), .out_last(out_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Exact constant multiplier (approximation request does not alter the product here)
  always_comb mult_result = 14'($signed({1'b0, mult_coeff}) * mult_mcand);

  function automatic int ref_x(input int k);
    int s = 0;
    for (int n = 0; n < 8; n++) s += MAT[k][n] * int'(xv[n]);
`ifdef DCT_ROUND_SHIFT_EN
    s = (s + 32) >>> 6;
`endif
    return s;
  endfunction

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic pack_xv();
    for (int i = 0; i < 8; i++) in_data[i*SIZE +: SIZE] = xv[i];
  endtask

  task automatic wait_valid(output int cyc, output bit ok);
    cyc = 0;
    ok  = 1'b0;
    while (cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
      if (toggle_g) approx_en_in = ~approx_en_in;
      if (out_valid) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic accept_vec(input bit appr);
    @(posedge clk); #1;
    pack_xv();
    approx_en_in = appr;
    in_valid = 1'b1;
    chk("in_ready_idle", in_ready, 1);
    chk("coeff_idle", mult_coeff, 0);
    chk("mcand_idle", mult_mcand, 0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_data  = 64'({$urandom(), $urandom()});
  endtask

  task automatic run_vec(input bit appr, input bit toggle, input bit stall3);
    int cyc;
    bit ok;
    logic signed [ACC_W-1:0] held;
    accept_vec(appr);
    toggle_g = toggle;
    for (int k = 0; k < 8; k++) begin
      wait_valid(cyc, ok);
      if (!ok) begin
        chk("timeout", 0, 1);
        toggle_g = 1'b0;
        return;
      end
      if (k == 0) chk("latency_k0", cyc, 8);
      chk($sformatf("out_data_k%0d", k), out_data, ref_x(k));
      chk("out_idx", out_idx, k);
      chk("out_last", out_last, (k == 7) ? 1 : 0);
      chk("approx_latched", mult_approx_en, appr);
      chk("in_ready_busy", in_ready, 0);
      if (stall3 && k == 3) begin
        out_ready = 1'b0;
        held = out_data;
        repeat (5) begin
          in_valid = 1'b1;
          in_data  = 64'({$urandom(), $urandom()});
          @(posedge clk); #1;
          chk("stall_valid", out_valid, 1);
          chk("stall_data", out_data, held);
          chk("stall_idx", out_idx, 3);
          chk("stall_in_ready", in_ready, 0);
          chk("stall_coeff", mult_coeff, 0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
      end
    end
    toggle_g = 1'b0;
    @(posedge clk); #1;
    chk("end_valid", out_valid, 0);
    chk("end_in_ready", in_ready, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    bit ok;
    rst_n = 1'b0;
    in_valid = 1'b0;
    in_data = '0;
    approx_en_in = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_idx", out_idx, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_approx", mult_approx_en, 0);
    rst_n = 1'b1;
    #1;
    chk("post_rst_in_ready", in_ready, 1);

    for (int i = 0; i < 8; i++) xv[i] = 8'sd1;
    run_vec(1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 8; i++) xv[i] = 8'sd0;
    xv[0] = 8'sd10;
    run_vec(1'b1, 1'b1, 1'b0);

    for (int i = 0; i < 8; i++) xv[i] = -8'sd128;
    run_vec(1'b0, 1'b1, 1'b0);

    for (int i = 0; i < 8; i++) xv[i] = 8'($urandom_range(0, 255));
    run_vec(1'b1, 1'b0, 1'b1);

    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 8; i++) xv[i] = 8'($urandom_range(0, 255));
      run_vec(1'($urandom_range(0, 1)), 1'b1, 1'b0);
    end

    // Abort a vector with reset at k=2, n=4
    for (int i = 0; i < 8; i++) xv[i] = 8'($urandom_range(0, 255));
    accept_vec(1'b1);
    wait_valid(cyc, ok);
    if (!ok) chk("abort_timeout0", 0, 1);
    wait_valid(cyc, ok);
    if (!ok) chk("abort_timeout1", 0, 1);
    repeat (5) @(posedge clk);
    #1;
    chk("abort_coeff", mult_coeff, iabs(MAT[2][4]));
    chk("abort_mcand", mult_mcand, xv[4]);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("abort_valid", out_valid, 0);
    chk("abort_in_ready", in_ready, 0);
    chk("abort_idx", out_idx, 0);
    chk("abort_last", out_last, 0);
    chk("abort_coeff0", mult_coeff, 0);
    chk("abort_approx", mult_approx_en, 0);
    rst_n = 1'b1;
    #1;
    chk("abort_idle_ready", in_ready, 1);

    for (int i = 0; i < 8; i++) xv[i] = 8'sd0;
    xv[0] = 8'sd1;
    run_vec(1'b0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
